// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one RV32I instruction per accepted beat into an
// ALU select code plus operands, and holds the result in a one-entry issue
// register under a valid/ready handshake. A flush drops the held entry and
// any beat offered in the same cycle.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_SLL  = 4'b0010;
  localparam logic [3:0] SEL_SLT  = 4'b0011;
  localparam logic [3:0] SEL_SLTU = 4'b0100;
  localparam logic [3:0] SEL_XOR  = 4'b0101;
  localparam logic [3:0] SEL_SRL  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_OR   = 4'b1000;
  localparam logic [3:0] SEL_AND  = 4'b1001;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  logic [3:0]  dec_sel;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  logic        accept;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // All immediates sign-extend from instr[31]; the U form has no extension
  // because bit 31 already sits in place.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};

  // in_ready depends only on the register state, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Decode: opcode selects operand sources, funct fields pick the ALU op.
  always_comb begin
    dec_sel     = SEL_ADD;
    dec_a       = rs1_data;
    dec_b       = imm_i;
    dec_rd      = instr[11:7];
    dec_illegal = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000: dec_sel = SEL_ADD;
            3'b001: dec_sel = SEL_SLL;
            3'b010: dec_sel = SEL_SLT;
            3'b011: dec_sel = SEL_SLTU;
            3'b100: dec_sel = SEL_XOR;
            3'b101: dec_sel = SEL_SRL;
            3'b110: dec_sel = SEL_OR;
            3'b111: dec_sel = SEL_AND;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_sel = SEL_SUB;
          end else if (funct3 == 3'b101) begin
            dec_sel = SEL_SRA;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end

      // Only the shifts carry a funct7; for the other OP-IMM forms those
      // bits are the upper immediate and are not constrained. The shift
      // amount lands in operand_b[4:0] through the I-immediate.
      OPC_OP_IMM: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        unique case (funct3)
          3'b000: dec_sel = SEL_ADD;
          3'b010: dec_sel = SEL_SLT;
          3'b011: dec_sel = SEL_SLTU;
          3'b100: dec_sel = SEL_XOR;
          3'b110: dec_sel = SEL_OR;
          3'b111: dec_sel = SEL_AND;
          3'b001: begin
            dec_sel = SEL_SLL;
            if (funct7 != F7_BASE) dec_illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              dec_sel = SEL_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_sel = SEL_SRA;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        dec_sel = SEL_PASS;
        dec_a   = 32'd0;
        dec_b   = imm_u;
      end

      OPC_AUIPC: begin
        dec_sel = SEL_ADD;
        dec_a   = pc;
        dec_b   = imm_u;
      end

      OPC_LOAD: begin
        dec_sel = SEL_ADD;
        dec_a   = rs1_data;
        dec_b   = imm_i;
      end

      OPC_STORE: begin
        dec_sel = SEL_ADD;
        dec_a   = rs1_data;
        dec_b   = imm_s;
        dec_rd  = 5'd0;
      end

      // Jumps compute the link value pc+4; the target is resolved elsewhere.
      OPC_JAL, OPC_JALR: begin
        dec_sel = SEL_ADD;
        dec_a   = pc;
        dec_b   = 32'd4;
      end

      OPC_BRANCH: begin
        dec_sel = SEL_SUB;
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_rd  = 5'd0;
      end

      default: dec_illegal = 1'b1;
    endcase

    // Any illegal encoding, whether from opcode or funct, issues a clean
    // zeroed entry so EX never sees partially decoded operands.
    if (dec_illegal) begin
      dec_sel = SEL_ADD;
      dec_a   = 32'd0;
      dec_b   = 32'd0;
      dec_rd  = 5'd0;
    end
  end

  // Valid flag: flush wins over accept, accept wins over consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload register loads only on accept, so it holds during a stall and
  // keeps stale contents after a flush or consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_sel   <= SEL_ADD;
      operand_a <= 32'd0;
      operand_b <= 32'd0;
      rd        <= 5'd0;
      illegal   <= 1'b0;
    end else if (accept) begin
      alu_sel   <= dec_sel;
      operand_a <= dec_a;
      operand_b <= dec_b;
      rd        <= dec_rd;
      illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode vectors, handshake,
// backpressure, flush and asynchronous reset.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_sel   (alu_sel),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd        (rd),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v;
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_sel !== 4'h0 ||
        operand_a !== 32'h0 || operand_b !== 32'h0 || rd !== 5'h0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b sel=%h a=%h b=%h rd=%0d ill=%b, required 0/1/0/0/0/0/0",
               out_valid, in_ready, alu_sel, operand_a, operand_b, rd, illegal);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_decode();
    vec_t v [14];
    v[0]  = '{32'h00500093, 32'h0,   32'h0,        32'h0,        4'h0, 32'h0,        32'h5,        5'd1, 1'b0}; // addi x1,x0,5
    v[1]  = '{32'h402081B3, 32'h0,   32'h00000010, 32'h00000003, 4'h1, 32'h00000010, 32'h00000003, 5'd3, 1'b0}; // sub
    v[2]  = '{32'h40335293, 32'h0,   32'h80000000, 32'h0,        4'h7, 32'h80000000, 32'h00000403, 5'd5, 1'b0}; // srai x5,x6,3
    v[3]  = '{32'h123453B7, 32'h0,   32'hDEADBEEF, 32'h0,        4'hF, 32'h0,        32'h12345000, 5'd7, 1'b0}; // lui
    v[4]  = '{32'h00001097, 32'h100, 32'hDEADBEEF, 32'h0,        4'h0, 32'h00000100, 32'h00001000, 5'd1, 1'b0}; // auipc
    v[5]  = '{32'hFFF00093, 32'h0,   32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFFFF, 5'd1, 1'b0}; // addi -1
    v[6]  = '{32'h0020A423, 32'h0,   32'h00001000, 32'h55,       4'h0, 32'h00001000, 32'h00000008, 5'd0, 1'b0}; // sw 8
    v[7]  = '{32'hFE20AE23, 32'h0,   32'h00001000, 32'h55,       4'h0, 32'h00001000, 32'hFFFFFFFC, 5'd0, 1'b0}; // sw -4
    v[8]  = '{32'h00208063, 32'h0,   32'h00000007, 32'h00000009, 4'h1, 32'h00000007, 32'h00000009, 5'd0, 1'b0}; // beq
    v[9]  = '{32'h000000EF, 32'h200, 32'h0,        32'h0,        4'h0, 32'h00000200, 32'h00000004, 5'd1, 1'b0}; // jal x1
    v[10] = '{32'h4020D1B3, 32'h0,   32'hF0000000, 32'h00000004, 4'h7, 32'hF0000000, 32'h00000004, 5'd3, 1'b0}; // sra
    v[11] = '{32'h0020F1B3, 32'h0,   32'h0000FF00, 32'h00000F0F, 4'h9, 32'h0000FF00, 32'h00000F0F, 5'd3, 1'b0}; // and
    v[12] = '{32'h022081B3, 32'h0,   32'h1,        32'h2,        4'h0, 32'h0,        32'h0,        5'd0, 1'b1}; // mul: illegal
    v[13] = '{32'h00000000, 32'h0,   32'h1,        32'h2,        4'h0, 32'h0,        32'h0,        5'd0, 1'b1}; // opcode 0
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      offer(1'b1, v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_sel !== v[i].sel || operand_a !== v[i].a ||
          operand_b !== v[i].b || rd !== v[i].rd || illegal !== v[i].ill) begin
        errors++;
        $display("FAIL decode[%0d] instr=%h: got v=%b sel=%h a=%h b=%h rd=%0d ill=%b, required v=1 sel=%h a=%h b=%h rd=%0d ill=%b",
                 i, v[i].instr, out_valid, alu_sel, operand_a, operand_b, rd, illegal,
                 v[i].sel, v[i].a, v[i].b, v[i].rd, v[i].ill);
      end
    end
    // SLLI with a nonzero funct7 is illegal.
    offer(1'b1, 32'h40311293, 32'h0, 32'h3, 32'h0);
    step();
    checks++;
    if (illegal !== 1'b1 || alu_sel !== 4'h0) begin
      errors++;
      $display("FAIL slli_bad_funct7: ill=%b sel=%h, required ill=1 sel=0", illegal, alu_sel);
    end
    offer(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    offer(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0); // addi x1,x0,1
    step();
    out_ready = 1'b0;
    offer(1'b1, 32'h00200113, 32'h0, 32'h0, 32'h0); // addi x2,x0,2
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 5'd1 || operand_b !== 32'd1) begin
        errors++;
        $display("FAIL stall[%0d]: ready=%b valid=%b rd=%0d b=%h, required 0/1/1/1",
                 c, in_ready, out_valid, rd, operand_b);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || rd !== 5'(k) || operand_b !== 32'(k)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b rd=%0d b=%h, required 1/%0d/%0d",
                 k, out_valid, rd, operand_b, k, k);
      end
      if (k < 4) begin
        offer(1'b1, {12'(k + 1), 5'd0, 3'b000, 5'(k + 1), 7'b0010011}, 32'h0, 32'h0, 32'h0);
      end else begin
        offer(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(1'b1, 32'h00700393, 32'h0, 32'h0, 32'h0); // addi x7,x0,7
    step();
    checks++;
    if (out_valid !== 1'b1 || rd !== 5'd7) begin
      errors++;
      $display("FAIL flush_setup: valid=%b rd=%0d, required 1/7", out_valid, rd);
    end
    flush = 1'b1;
    offer(1'b1, 32'h00900493, 32'h0, 32'h0, 32'h0); // addi x9,x0,9
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: out_valid=%b, required 0", out_valid);
    end
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || rd === 5'd9) begin
        errors++;
        $display("FAIL flush_drop[%0d]: valid=%b rd=%0d, required valid 0 and rd not 9",
                 c, out_valid, rd);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(1'b1, 32'h40335293, 32'h0, 32'h12345678, 32'h0); // srai x5,x6,3
    step();
    checks++;
    if (out_valid !== 1'b1 || operand_a !== 32'h12345678) begin
      errors++;
      $display("FAIL areset_setup: valid=%b a=%h, required 1/12345678", out_valid, operand_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_sel !== 4'h0 ||
        operand_a !== 32'h0 || operand_b !== 32'h0 || rd !== 5'h0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL areset: valid=%b ready=%b sel=%h a=%h b=%h rd=%0d ill=%b, required 0/1/0/0/0/0/0",
               out_valid, in_ready, alu_sel, operand_a, operand_b, rd, illegal);
    end
    offer(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;

    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
